// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the simple ALU logic path.
//   - OP_W and the logic-unit opcode encodings (OP_AND .. OP_ILLEGAL)
//   - flags_t : result flag bundle, ordered {negative, zero, cout, overflow}
//   - arb_state_t : occupancy state of the one-entry result register
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND     = 3'b000;
    localparam logic [OP_W-1:0] OP_NAND    = 3'b001;
    localparam logic [OP_W-1:0] OP_OR      = 3'b010;
    localparam logic [OP_W-1:0] OP_NOR     = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR     = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR    = 3'b101;
    localparam logic [OP_W-1:0] OP_NOT     = 3'b110;
    localparam logic [OP_W-1:0] OP_ILLEGAL = 3'b111;

    typedef struct packed {
        logic negative;
        logic zero;
        logic cout;
        logic overflow;
    } flags_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

    // True when the opcode is the reserved (illegal) encoding.
    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return (op == OP_ILLEGAL);
    endfunction

endpackage

// File: rtl/logic_unit.sv
// ---------------------------------------------------------------------------
// logic_unit
//   Purely combinational bitwise logic unit.
//   Ports:
//     op      in  OP_W   opcode (AND/NAND/OR/NOR/XOR/XNOR/NOT x/illegal)
//     x, y    in  WIDTH  operands (y unused for NOT)
//     r       out WIDTH  result (0 for the illegal opcode)
//     flags   out        {negative, zero, cout, overflow}; cout/overflow are 0
//     illegal out 1      opcode was the reserved encoding
// ---------------------------------------------------------------------------
module logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] r,
    output flags_t           flags,
    output logic             illegal
);

    always_comb begin
        r       = '0;
        illegal = 1'b0;
        case (op)
            OP_AND:  r = x & y;
            OP_NAND: r = ~(x & y);
            OP_OR:   r = x | y;
            OP_NOR:  r = ~(x | y);
            OP_XOR:  r = x ^ y;
            OP_XNOR: r = ~(x ^ y);
            OP_NOT:  r = ~x;
            // Reserved opcode: still produces a (zero) result so the slot
            // is consumed and the requester is not stalled.
            default: illegal = is_illegal_op(op);
        endcase
    end

    // A pure logic unit never carries or overflows.
    always_comb begin
        flags.negative = r[WIDTH-1];
        flags.zero     = (r == '0);
        flags.cout     = 1'b0;
        flags.overflow = 1'b0;
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
//   Shares one logic_unit between two requesters with round-robin
//   arbitration and a one-entry registered result.
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     reqN_valid/ready            request handshake (N = 0, 1)
//     reqN_op/x/y                 request opcode and operands
//     out_valid/out_ready         result handshake
//     out_r, out_id               held result and the requester it came from
//     out_negative/zero/cout/overflow/illegal   flags of the held result
// ---------------------------------------------------------------------------
module logic_unit_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic             out_id,
    output logic             out_negative,
    output logic             out_zero,
    output logic             out_cout,
    output logic             out_overflow,
    output logic             out_illegal
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t       state_q,   state_d;
    logic             rr_ptr_q,  rr_ptr_d;
    logic [WIDTH-1:0] out_r_q,   out_r_d;
    logic             out_id_q,  out_id_d;
    flags_t           flags_q,   flags_d;
    logic             illegal_q, illegal_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             grant_any;

    // The result slot can take a new op when empty, or when the held
    // result leaves this very cycle (full throughput).
    assign can_accept = (state_q == ST_EMPTY) || out_ready;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (can_accept) begin
            if (req0_valid && req1_valid) begin
                // rr_ptr names the requester that wins a tie.
                grant0 = ~rr_ptr_q;
                grant1 =  rr_ptr_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign grant_any  = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // ------------------------------------------------------------------
    // Operand mux and shared logic unit
    // ------------------------------------------------------------------
    logic [OP_W-1:0]  sel_op;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic [WIDTH-1:0] lu_r;
    flags_t           lu_flags;
    logic             lu_illegal;

    always_comb begin
        sel_op = req0_op;
        sel_x  = req0_x;
        sel_y  = req0_y;
        if (grant1) begin
            sel_op = req1_op;
            sel_x  = req1_x;
            sel_y  = req1_y;
        end
    end

    logic_unit #(
        .WIDTH   (WIDTH)
    ) u_logic_unit (
        .op      (sel_op),
        .x       (sel_x),
        .y       (sel_y),
        .r       (lu_r),
        .flags   (lu_flags),
        .illegal (lu_illegal)
    );

    // ------------------------------------------------------------------
    // Next-state / output-register logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        out_r_d   = out_r_q;
        out_id_d  = out_id_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;

        // Any grant loads a fresh result; it replaces an outgoing one.
        if (grant_any) begin
            out_r_d   = lu_r;
            out_id_d  = grant1;
            flags_d   = lu_flags;
            illegal_d = lu_illegal;
            rr_ptr_d  = ~grant1;
        end

        case (state_q)
            ST_EMPTY: begin
                if (grant_any) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready && !grant_any) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            rr_ptr_q  <= 1'b0;
            out_r_q   <= '0;
            out_id_q  <= 1'b0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            out_r_q   <= out_r_d;
            out_id_q  <= out_id_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid    = (state_q == ST_FULL);
    assign out_r        = out_r_q;
    assign out_id       = out_id_q;
    assign out_negative = flags_q.negative;
    assign out_zero     = flags_q.zero;
    assign out_cout     = flags_q.cout;
    assign out_overflow = flags_q.overflow;
    assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_ready;
    logic [2:0]   req0_op;
    logic [W-1:0] req0_x, req0_y;
    logic         req1_valid, req1_ready;
    logic [2:0]   req1_op;
    logic [W-1:0] req1_x, req1_y;
    logic         out_valid, out_ready;
    logic [W-1:0] out_r;
    logic         out_id, out_negative, out_zero, out_cout, out_overflow, out_illegal;

    int errors;
    int checks;

    // Reference model: contents of the result slot plus which requester
    // wins the next tie.
    bit           m_valid;
    logic [W-1:0] m_r;
    bit           m_id;
    bit           m_ill;
    int           m_pref;

    // Requests currently presented by each requester.
    bit           t_v  [2];
    logic [2:0]   t_op [2];
    logic [W-1:0] t_x  [2];
    logic [W-1:0] t_y  [2];

    logic_unit_arbiter #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op      (req0_op),
        .req0_x       (req0_x),
        .req0_y       (req0_y),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op      (req1_op),
        .req1_x       (req1_x),
        .req1_y       (req1_y),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_r        (out_r),
        .out_id       (out_id),
        .out_negative (out_negative),
        .out_zero     (out_zero),
        .out_cout     (out_cout),
        .out_overflow (out_overflow),
        .out_illegal  (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Model helpers (no comparisons in here)
    // ------------------------------------------------------------------
    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        case (op)
            3'd0:    return x & y;
            3'd1:    return ~(x & y);
            3'd2:    return x | y;
            3'd3:    return ~(x | y);
            3'd4:    return x ^ y;
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_r     = '0;
        m_id    = 0;
        m_ill   = 0;
        m_pref  = 0;
    endtask

    task automatic apply();
        req0_valid = t_v[0]; req0_op = t_op[0]; req0_x = t_x[0]; req0_y = t_y[0];
        req1_valid = t_v[1]; req1_op = t_op[1]; req1_x = t_x[1]; req1_y = t_y[1];
    endtask

    task automatic set_req(input int n, input bit v, input logic [2:0] op,
                           input logic [W-1:0] x, input logic [W-1:0] y);
        t_v[n] = v; t_op[n] = op; t_x[n] = x; t_y[n] = y;
    endtask

    task automatic new_req(input int n, input bit v);
        set_req(n, v, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    endtask

    // Which requester should be granted this cycle: -1 none.
    function automatic int predict();
        if (m_valid && !out_ready) return -1;
        if (t_v[0] && t_v[1])      return m_pref;
        if (t_v[0])                return 0;
        if (t_v[1])                return 1;
        return -1;
    endfunction

    task automatic commit(input int g);
        if (g >= 0) begin
            m_valid = 1;
            m_id    = (g == 1);
            m_r     = ref_op(t_op[g], t_x[g], t_y[g]);
            m_ill   = (t_op[g] == 3'b111);
            m_pref  = 1 - g;
        end else if (out_ready) begin
            m_valid = 0;
        end
    endtask

    function automatic logic [1:0] exp_rdy(input int g);
        return (g == 0) ? 2'b10 : (g == 1) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [14:0] obs_vec();
        return {out_valid, out_r, out_id, out_negative, out_zero, out_cout, out_overflow, out_illegal};
    endfunction

    function automatic logic [14:0] exp_vec();
        return {m_valid, m_r, m_id, m_r[W-1], (m_r == '0), 1'b0, 1'b0, m_ill};
    endfunction

    // When empty only valid/cout/overflow are meaningful.
    function automatic logic [14:0] vmask();
        return m_valid ? 15'h7FFF : 15'h4006;
    endfunction

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        int g;
        rst_n = 0;
        out_ready = 0;
        set_req(0, 1, 3'd0, 8'hFF, 8'h0F);
        set_req(1, 1, 3'd2, 8'h11, 8'h22);
        apply();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs_vec(), 15'h0);
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        #1;
        g = predict();
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_first_grant: ready=%b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        commit(g);
        checks++;
        if ((obs_vec() & vmask()) !== (exp_vec() & vmask())) begin
            errors++;
            $display("FAIL reset_first_result: got %h expected %h", obs_vec(), exp_vec());
        end
        $display("reset: first result id=%0d r=%h", out_id, out_r);
        // drain
        t_v[0] = 0; t_v[1] = 0; out_ready = 1; apply(); #1;
        g = predict();
        @(posedge clk); #1;
        commit(g);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_single_op();
        int g;
        out_ready = 1;
        set_req(0, 1, 3'd0, 8'hF0, 8'h3C);
        t_v[1] = 0;
        apply(); #1;
        g = predict();
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL and_ready: ready=%b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        commit(g);
        checks++;
        if (obs_vec() !== {1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL and_result: got %h expected %h", obs_vec(),
                     {1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        $display("single: AND F0,3C -> r=%h id=%0d", out_r, out_id);

        t_v[0] = 0;
        set_req(1, 1, 3'd5, 8'hAA, 8'hAA);
        apply(); #1;
        g = predict();
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL xnor_ready: ready=%b expected 01", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        commit(g);
        checks++;
        if (obs_vec() !== {1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL xnor_result: got %h expected %h", obs_vec(),
                     {1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        $display("single: XNOR AA,AA -> r=%h id=%0d", out_r, out_id);

        t_v[1] = 0; apply(); #1;
        g = predict();
        @(posedge clk); #1;
        commit(g);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_illegal_not();
        int g;
        out_ready = 1;
        t_v[1] = 0;
        set_req(0, 1, 3'b111, 8'hFF, 8'h5A);
        apply(); #1;
        g = predict();
        @(posedge clk); #1;
        commit(g);
        checks++;
        if (obs_vec() !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL illegal_result: got %h expected %h", obs_vec(),
                     {1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        end
        $display("illegal: op=111 -> r=%h zero=%b illegal=%b", out_r, out_zero, out_illegal);

        set_req(0, 1, 3'b110, 8'h00, 8'h77);
        apply(); #1;
        g = predict();
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL not_ready: ready=%b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        commit(g);
        checks++;
        if (obs_vec() !== {1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL not_result: got %h expected %h", obs_vec(),
                     {1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        $display("not: op=110 x=00 -> r=%h neg=%b", out_r, out_negative);
        t_v[0] = 0;
    endtask

    task automatic test_contention();
        int g;
        out_ready = 1;
        new_req(0, 1);
        new_req(1, 1);
        for (int i = 0; i < 8; i++) begin
            apply(); #1;
            g = predict();
            checks++;
            if ({req0_ready, req1_ready} !== exp_rdy(g)) begin
                errors++;
                $display("FAIL contention_grant[%0d]: ready=%b expected %b", i,
                         {req0_ready, req1_ready}, exp_rdy(g));
            end
            @(posedge clk); #1;
            commit(g);
            checks++;
            if ((obs_vec() & vmask()) !== (exp_vec() & vmask())) begin
                errors++;
                $display("FAIL contention_result[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            $display("contention[%0d]: grant=%0d r=%h id=%0d", i, g, out_r, out_id);
            if (g >= 0) new_req(g, 1);
        end
    endtask

    task automatic test_backpressure();
        int g;
        out_ready = 1;
        apply(); #1;
        g = predict();
        @(posedge clk); #1;
        commit(g);
        if (g >= 0) new_req(g, 1);
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            apply(); #1;
            g = predict();
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                errors++;
                $display("FAIL bp_ready[%0d]: ready=%b expected 00", i, {req0_ready, req1_ready});
            end
            @(posedge clk); #1;
            commit(g);
            checks++;
            if ((obs_vec() & vmask()) !== (exp_vec() & vmask())) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            $display("backpressure[%0d]: held r=%h id=%0d", i, out_r, out_id);
        end
        out_ready = 1;
        apply(); #1;
        g = predict();
        checks++;
        if ({req0_ready, req1_ready} !== exp_rdy(g) || g < 0) begin
            errors++;
            $display("FAIL bp_release_grant: ready=%b expected %b", {req0_ready, req1_ready}, exp_rdy(g));
        end
        @(posedge clk); #1;
        commit(g);
        checks++;
        if ((obs_vec() & vmask()) !== (exp_vec() & vmask())) begin
            errors++;
            $display("FAIL bp_release_result: got %h expected %h", obs_vec(), exp_vec());
        end
        $display("backpressure: released, grant=%0d r=%h", g, out_r);
        if (g >= 0) t_v[g] = 0;
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < 250; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            for (int n = 0; n < 2; n++)
                if (!t_v[n] && $urandom_range(0, 1) == 1) new_req(n, 1);
            apply(); #1;
            g = predict();
            checks++;
            if ({req0_ready, req1_ready} !== exp_rdy(g)) begin
                errors++;
                $display("FAIL random_grant[%0d]: ready=%b expected %b", i,
                         {req0_ready, req1_ready}, exp_rdy(g));
            end
            @(posedge clk); #1;
            commit(g);
            checks++;
            if ((obs_vec() & vmask()) !== (exp_vec() & vmask())) begin
                errors++;
                $display("FAIL random_result[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (g >= 0) begin
                $display("random[%0d]: grant=%0d op=%0d r=%h", i, g, t_op[g], out_r);
                t_v[g] = 0;
            end
        end
    endtask

    task automatic test_reset_mid();
        int g;
        // drain, then grant req0 so the tie pointer favours req1
        t_v[0] = 0; t_v[1] = 0; out_ready = 1; apply(); #1;
        g = predict();
        @(posedge clk); #1; commit(g);
        new_req(0, 1); apply(); #1;
        g = predict();
        @(posedge clk); #1; commit(g);
        // both valid, consumer stalled -> slot stays full
        new_req(0, 1); new_req(1, 1); out_ready = 0; apply(); #1;
        g = predict();
        @(posedge clk); #1; commit(g);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: out_valid=%b expected 1", out_valid);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (obs_vec() !== 15'h0) begin
            errors++;
            $display("FAIL midreset_async: got %h expected %h", obs_vec(), 15'h0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        #1;
        g = predict();
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_rr: ready=%b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        commit(g);
        checks++;
        if ((obs_vec() & vmask()) !== (exp_vec() & vmask())) begin
            errors++;
            $display("FAIL midreset_result: got %h expected %h", obs_vec(), exp_vec());
        end
        $display("midreset: after release grant=%0d id=%0d", g, out_id);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        model_reset();
        for (int n = 0; n < 2; n++) set_req(n, 0, 3'd0, '0, '0);
        rst_n = 0;
        out_ready = 0;
        apply();
        test_reset();
        test_single_op();
        test_illegal_not();
        test_contention();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
